spart_host_ctrl: RTL

- Sequences the SPART register interface on behalf of the image-processing datapath.
- After reset, programs the baud divisor. It then services received bytes into a small FIFO and shares the transmitter between two requesters using round-robin arbitration.
- Replaces ad-hoc driver logic. It is the only master of the SPART iocs/iorw/ioaddr bus.

---
 rtl/spart_host_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/spart_host_ctrl.sv
// Sole master of the SPART register bus: programs the baud divisor, drains received
// bytes into a small FIFO and shares the transmitter between two round-robin requesters.
module spart_host_ctrl #(
   parameter logic [15:0] DIV_DEFAULT = 16'd325,
   parameter int unsigned RX_DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        iocs,
   output logic        iorw,
   output logic [1:0]  ioaddr,
   output logic [7:0]  wdata,
   input  logic [7:0]  rdata,
   input  logic        rda,
   input  logic        tbr,
   input  logic        cfg_req,
   input  logic [15:0] cfg_div,
   output logic        cfg_done,
   input  logic        tx0_valid,
   input  logic        tx1_valid,
   input  logic [7:0]  tx0_data,
   input  logic [7:0]  tx1_data,
   output logic        tx0_ready,
   output logic        tx1_ready,
   output logic        rx_valid,
   output logic [7:0]  rx_data,
   input  logic        rx_ready
);

   localparam int unsigned PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [2:0] S_CFG_LO = 3'd0;
   localparam logic [2:0] S_CFG_HI = 3'd1;
   localparam logic [2:0] S_IDLE   = 3'd2;
   localparam logic [2:0] S_RX_RD  = 3'd3;
   localparam logic [2:0] S_TX_WR  = 3'd4;
   localparam logic [2:0] S_GUARD  = 3'd5;

   logic [2:0]  state_q, state_d;
   logic        iocs_q, iocs_d;
   logic        iorw_q, iorw_d;
   logic [1:0]  ioaddr_q, ioaddr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        tx0_ready_q, tx0_ready_d;
   logic        tx1_ready_q, tx1_ready_d;
   logic        rr_q, rr_d;
   logic [15:0] div_q, div_d;
   logic        pending_q, pending_d;
   logic        cfg_done_q, cfg_done_d;

   logic [7:0]       mem_q [RX_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] rd_nxt;
   logic [CNT_W-1:0] count_q, count_d;
   logic             rx_valid_q, rx_valid_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             push, pop, fifo_full;
   logic             grant, any_tx;

   assign iocs      = iocs_q;
   assign iorw      = iorw_q;
   assign ioaddr    = ioaddr_q;
   assign wdata     = wdata_q;
   assign tx0_ready = tx0_ready_q;
   assign tx1_ready = tx1_ready_q;
   assign cfg_done  = cfg_done_q;
   assign rx_valid  = rx_valid_q;
   assign rx_data   = rx_data_q;

   assign fifo_full = (count_q == CNT_W'(RX_DEPTH));
   assign any_tx    = tx0_valid | tx1_valid;

   // The bus outputs of a state appear in the cycle after that state is entered.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
      state_d     = state_q;
      iocs_d      = 1'b0;
      iorw_d      = 1'b1;
      ioaddr_d    = 2'b00;
      wdata_d     = wdata_q;
      tx0_ready_d = 1'b0;
      tx1_ready_d = 1'b0;
      rr_d        = rr_q;
      grant       = (tx0_valid & tx1_valid) ? rr_q : tx1_valid;
      case (state_q)
         S_CFG_LO: begin
            iocs_d   = 1'b1;
            iorw_d   = 1'b0;
            ioaddr_d = 2'b10;
            wdata_d  = div_q[7:0];
            state_d  = S_CFG_HI;
         end
         S_CFG_HI: begin
            iocs_d   = 1'b1;
            iorw_d   = 1'b0;
            ioaddr_d = 2'b11;
            wdata_d  = div_q[15:8];
            state_d  = S_IDLE;
         end
         S_IDLE: begin
            if (pending_q)             state_d = S_CFG_LO;
            else if (rda && !fifo_full) state_d = S_RX_RD;
            else if (tbr && any_tx)     state_d = S_TX_WR;
         end
         S_RX_RD: begin
            iocs_d  = 1'b1;
            state_d = S_GUARD;
         end
         S_TX_WR: begin
            // A requester that withdrew its valid meanwhile simply gets no write.
            if (any_tx) begin
               iocs_d      = 1'b1;
               iorw_d      = 1'b0;
               wdata_d     = grant ? tx1_data : tx0_data;
               tx0_ready_d = ~grant;
               tx1_ready_d = grant;
               rr_d        = ~grant;
            end
            state_d = S_GUARD;
         end
         S_GUARD: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      div_d      = cfg_req ? cfg_div : div_q;
      pending_d  = cfg_req ? 1'b1 : ((state_q == S_CFG_HI) ? 1'b0 : pending_q);
      cfg_done_d = ~pending_q & ~cfg_req;
   end

   // rdata is valid during the read strobe, so the push lands on the edge that ends it.
   always_comb begin
      push     = iocs_q & iorw_q;
      pop      = rx_valid_q & rx_ready;
      rd_nxt   = rd_ptr_q + 1'b1;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_nxt : rd_ptr_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      rx_valid_d = (count_d != '0);
      if (push && ((count_q == '0) || ((count_q == CNT_W'(1)) && pop)))
         rx_data_d = rdata;
      else if (pop)
         rx_data_d = mem_q[rd_nxt];
      else
         rx_data_d = rx_data_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_CFG_LO;
         iocs_q      <= 1'b0;
         iorw_q      <= 1'b1;
         ioaddr_q    <= 2'b00;
         wdata_q     <= 8'h00;
         tx0_ready_q <= 1'b0;
         tx1_ready_q <= 1'b0;
         rr_q        <= 1'b0;
         div_q       <= DIV_DEFAULT;
         pending_q   <= 1'b1;
         cfg_done_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rx_valid_q  <= 1'b0;
         rx_data_q   <= 8'h00;
      end else begin
         state_q     <= state_d;
         iocs_q      <= iocs_d;
         iorw_q      <= iorw_d;
         ioaddr_q    <= ioaddr_d;
         wdata_q     <= wdata_d;
         tx0_ready_q <= tx0_ready_d;
         tx1_ready_q <= tx1_ready_d;
         rr_q        <= rr_d;
         div_q       <= div_d;
         pending_q   <= pending_d;
         cfg_done_q  <= cfg_done_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rx_valid_q  <= rx_valid_d;
         rx_data_q   <= rx_data_d;
      end
   end

   // NOTE: FIFO storage is not reset; reset empties it via the pointers and count alone.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= rdata;
   end

endmodule
